// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register numbers, exception type codes, Cause/Status field
// positions and the exception-type decoder used by the register file.
package cp0_reg_pkg;

   localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
   localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
   localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_REG_EPC     = 5'd14;
   localparam logic [4:0] CP0_REG_PRID    = 5'd15;
   localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

   localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
   localparam logic [31:0] EXC_RI        = 32'h0000_000a;
   localparam logic [31:0] EXC_OV        = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

   localparam logic [4:0] EXCCODE_INT = 5'h00;
   localparam logic [4:0] EXCCODE_SYS = 5'h08;
   localparam logic [4:0] EXCCODE_RI  = 5'h0a;
   localparam logic [4:0] EXCCODE_OV  = 5'h0c;
   localparam logic [4:0] EXCCODE_TR  = 5'h0d;

   localparam int unsigned STATUS_EXL_BIT = 1;
   localparam int unsigned CAUSE_BD_BIT   = 31;

   // Software-writable Cause bits: IV, WP and the two software interrupt pending bits.
   localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

   typedef enum logic [1:0] {
      ExcNone,
      ExcTake,
      ExcEret
   } exc_kind_e;

   typedef struct packed {
      exc_kind_e  kind;
      logic [4:0] code;
   } exc_dec_t;

   function automatic exc_dec_t decode_exc(input logic [31:0] i_type);
      exc_dec_t w_dec;
      w_dec.kind = ExcNone;
      w_dec.code = 5'h00;
      case (i_type)
         EXC_INTERRUPT: begin w_dec.kind = ExcTake; w_dec.code = EXCCODE_INT; end
         EXC_SYSCALL:   begin w_dec.kind = ExcTake; w_dec.code = EXCCODE_SYS; end
         EXC_RI:        begin w_dec.kind = ExcTake; w_dec.code = EXCCODE_RI;  end
         EXC_OV:        begin w_dec.kind = ExcTake; w_dec.code = EXCCODE_OV;  end
         EXC_TRAP:      begin w_dec.kind = ExcTake; w_dec.code = EXCCODE_TR;  end
         EXC_ERET:      w_dec.kind = ExcEret;
         default:       w_dec.kind = ExcNone;
      endcase
      return w_dec;
   endfunction

endpackage

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, Config, PRId,
// fed by the write-back CP0 write channel and the MEM-stage exception report.
module cp0_reg
   import cp0_reg_pkg::*;
#(
   parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
   parameter logic [31:0] CONFIG_RST = 32'h0000_8000,
   parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   output logic [31:0] data_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic [31:0] r_status;
   logic [31:0] r_cause;
   logic [31:0] r_epc;
   logic        r_timer_int;

   logic [31:0] w_count_nxt;
   logic [31:0] w_compare_nxt;
   logic [31:0] w_status_nxt;
   logic [31:0] w_cause_nxt;
   logic [31:0] w_epc_nxt;
   logic        w_timer_int_nxt;
   exc_dec_t    w_exc;

   assign w_exc = decode_exc(excepttype_i);

   // Steps are ordered so that later assignments win: increment/IP sampling, timer match,
   // software write, then exception.
   always_comb begin
      w_count_nxt     = r_count + 32'd1;
      w_compare_nxt   = r_compare;
      w_status_nxt    = r_status;
      w_cause_nxt     = r_cause;
      w_epc_nxt       = r_epc;
      w_timer_int_nxt = r_timer_int;

      w_cause_nxt[15:10] = int_i;

      if ((r_compare != 32'd0) && (r_count == r_compare)) begin
         w_timer_int_nxt = 1'b1;
      end

      if (we_i) begin
         case (waddr_i)
            CP0_REG_COUNT:   w_count_nxt = data_i;
            CP0_REG_COMPARE: begin
               w_compare_nxt   = data_i;
               w_timer_int_nxt = 1'b0;
            end
            CP0_REG_STATUS:  w_status_nxt = data_i;
            CP0_REG_EPC:     w_epc_nxt = data_i;
            CP0_REG_CAUSE:   w_cause_nxt = (w_cause_nxt & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
            default:         ;
         endcase
      end

      case (w_exc.kind)
         ExcTake: begin
            // A nested exception keeps the original return point and BD flag.
            if (!r_status[STATUS_EXL_BIT]) begin
               if (is_in_delayslot_i) begin
                  w_epc_nxt                 = current_inst_addr_i - 32'd4;
                  w_cause_nxt[CAUSE_BD_BIT] = 1'b1;
               end else begin
                  w_epc_nxt                 = current_inst_addr_i;
                  w_cause_nxt[CAUSE_BD_BIT] = 1'b0;
               end
            end
            w_status_nxt[STATUS_EXL_BIT] = 1'b1;
            w_cause_nxt[6:2]             = w_exc.code;
         end
         ExcEret: w_status_nxt[STATUS_EXL_BIT] = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count     <= 32'd0;
         r_compare   <= 32'd0;
         r_status    <= STATUS_RST;
         r_cause     <= 32'd0;
         r_epc       <= 32'd0;
         r_timer_int <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_compare   <= w_compare_nxt;
         r_status    <= w_status_nxt;
         r_cause     <= w_cause_nxt;
         r_epc       <= w_epc_nxt;
         r_timer_int <= w_timer_int_nxt;
      end
   end

   // No write bypass: MFC0 forwarding from MEM/WB is handled upstream.
   always_comb begin
      data_o = 32'd0;
      case (raddr_i)
         CP0_REG_COUNT:   data_o = r_count;
         CP0_REG_COMPARE: data_o = r_compare;
         CP0_REG_STATUS:  data_o = r_status;
         CP0_REG_CAUSE:   data_o = r_cause;
         CP0_REG_EPC:     data_o = r_epc;
         CP0_REG_PRID:    data_o = PRID_VAL;
         CP0_REG_CONFIG:  data_o = CONFIG_RST;
         default:         data_o = 32'd0;
      endcase
   end

   assign count_o     = r_count;
   assign compare_o   = r_compare;
   assign status_o    = r_status;
   assign cause_o     = r_cause;
   assign epc_o       = r_epc;
   assign config_o    = CONFIG_RST;
   assign prid_o      = PRID_VAL;
   assign timer_int_o = r_timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed plus randomized bench for cp0_reg, checked against a cycle-level reference model.
module tb_cp0_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] data_i;
   logic [4:0]  raddr_i;
   logic [5:0]  int_i;
   logic [31:0] excepttype_i;
   logic [31:0] current_inst_addr_i;
   logic        is_in_delayslot_i;
   logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
   logic        timer_int_o;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
   logic        m_timer;
   int          exc_code [int];

   always #5 clk = ~clk;

   cp0_reg dut (
      .clk                 (clk),
      .rst                 (rst),
      .we_i                (we_i),
      .waddr_i             (waddr_i),
      .data_i              (data_i),
      .raddr_i             (raddr_i),
      .int_i               (int_i),
      .excepttype_i        (excepttype_i),
      .current_inst_addr_i (current_inst_addr_i),
      .is_in_delayslot_i   (is_in_delayslot_i),
      .data_o              (data_o),
      .count_o             (count_o),
      .compare_o           (compare_o),
      .status_o            (status_o),
      .cause_o             (cause_o),
      .epc_o               (epc_o),
      .config_o            (config_o),
      .prid_o              (prid_o),
      .timer_int_o         (timer_int_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return 32'h004c0102;
         5'd16:   return 32'h00008000;
         default: return 32'd0;
      endcase
   endfunction

   // One clock of architectural behaviour, from the pre-edge state and the current inputs.
   task automatic model_tick();
      logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
      logic        n_timer;
      int          et;
      if (!rst) begin
         m_count = 0; m_compare = 0; m_status = 32'h10000000; m_cause = 0; m_epc = 0;
         m_timer = 0;
         return;
      end
      n_count = m_count + 1; n_compare = m_compare; n_status = m_status;
      n_cause = m_cause; n_epc = m_epc;
      n_cause[15:10] = int_i;
      n_timer = m_timer || (m_compare != 0 && m_count == m_compare);
      if (we_i) begin
         if (waddr_i == 9) n_count = data_i;
         if (waddr_i == 11) begin n_compare = data_i; n_timer = 0; end
         if (waddr_i == 12) n_status = data_i;
         if (waddr_i == 14) n_epc = data_i;
         if (waddr_i == 13) n_cause = (n_cause & ~32'h00C00300) | (data_i & 32'h00C00300);
      end
      et = int'(excepttype_i);
      if (excepttype_i < 32'h100 && exc_code.exists(et)) begin
         if (!m_status[1]) begin
            n_epc = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
            n_cause[31] = is_in_delayslot_i;
         end
         n_status[1] = 1'b1;
         n_cause[6:2] = 5'(exc_code[et]);
      end else if (excepttype_i == 32'he) begin
         n_status[1] = 1'b0;
      end
      m_count = n_count; m_compare = n_compare; m_status = n_status;
      m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
   endtask

   task automatic check_model();
      chk("count", count_o, m_count);
      chk("compare", compare_o, m_compare);
      chk("status", status_o, m_status);
      chk("cause", cause_o, m_cause);
      chk("epc", epc_o, m_epc);
      chk("config", config_o, 32'h00008000);
      chk("prid", prid_o, 32'h004c0102);
      chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
      chk("data_o", data_o, model_read(raddr_i));
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
      check_model();
   endtask

   task automatic idle();
      we_i = 0; excepttype_i = 0; is_in_delayslot_i = 0;
   endtask

   initial begin
      logic [4:0] addrs [10];
      logic [31:0] etypes [7];
      addrs  = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd5, 5'd31};
      etypes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3};
      exc_code[1] = 0; exc_code[8] = 8; exc_code[10] = 10; exc_code[13] = 13; exc_code[12] = 12;

      rst = 0; we_i = 0; waddr_i = 0; data_i = 0; raddr_i = 5'd15; int_i = 0;
      excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0;
      tick(); tick();
      chk("rst_count", count_o, 32'd0);
      chk("rst_status", status_o, 32'h10000000);
      chk("rst_timer", {31'd0, timer_int_o}, 32'd0);

      rst = 1;
      repeat (5) tick();
      chk("idle_count5", count_o, 32'd5);
      chk("idle_prid_read", data_o, 32'h004c0102);
      chk("idle_config", config_o, 32'h00008000);

      // Timer: match fires when pre-increment count equals 10
      we_i = 1; waddr_i = 5'd11; data_i = 32'd10; raddr_i = 5'd11;
      tick();
      idle();
      for (int i = 0; i < 20 && count_o != 32'd11; i++) tick();
      chk("timer_count11", count_o, 32'd11);
      chk("timer_set", {31'd0, timer_int_o}, 32'd1);
      tick();
      chk("timer_sticky", {31'd0, timer_int_o}, 32'd1);
      we_i = 1; waddr_i = 5'd11; data_i = 32'd20;
      tick();
      idle();
      chk("timer_clear", {31'd0, timer_int_o}, 32'd0);

      // Cause write mask and hardware IP sampling
      we_i = 1; waddr_i = 5'd13; data_i = 32'hFFFFFFFF; raddr_i = 5'd13;
      tick();
      idle();
      chk("cause_wmask", cause_o, 32'h00C00300);
      int_i = 6'b101010;
      tick();
      chk("cause_ip_hw", {26'd0, cause_o[15:10]}, 32'b101010);
      int_i = 0;

      // Syscall in delay slot, then nested overflow
      excepttype_i = 32'h8; current_inst_addr_i = 32'h80001000; is_in_delayslot_i = 1;
      raddr_i = 5'd14;
      tick();
      chk("sys_epc", epc_o, 32'h80000FFC);
      chk("sys_bd", {31'd0, cause_o[31]}, 32'd1);
      chk("sys_code", {27'd0, cause_o[6:2]}, 32'h08);
      chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
      excepttype_i = 32'hc; current_inst_addr_i = 32'h80002000; is_in_delayslot_i = 0;
      tick();
      chk("ov_epc_kept", epc_o, 32'h80000FFC);
      chk("ov_code", {27'd0, cause_o[6:2]}, 32'h0c);

      excepttype_i = 32'he;
      tick();
      chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
      chk("eret_epc", epc_o, 32'h80000FFC);

      // Status write and exception in the same cycle
      we_i = 1; waddr_i = 5'd12; data_i = 32'h0000FF01; excepttype_i = 32'h8;
      current_inst_addr_i = 32'h80003000; raddr_i = 5'd12;
      tick();
      idle();
      chk("status_wr_exc", status_o, 32'h0000FF03);

      // Count wrap
      we_i = 1; waddr_i = 5'd9; data_i = 32'hFFFFFFFF;
      tick();
      idle();
      tick();
      chk("count_wrap", count_o, 32'd0);

      // Reset mid-run discards a concurrent write
      rst = 0; we_i = 1; waddr_i = 5'd12; data_i = 32'hFFFFFFFF;
      tick();
      chk("midrst_status", status_o, 32'h10000000);
      chk("midrst_count", count_o, 32'd0);
      chk("midrst_epc", epc_o, 32'd0);
      rst = 1; idle();

      // Randomized phase
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) != 0);
         we_i = $urandom_range(0, 1) == 1;
         waddr_i = addrs[$urandom_range(0, 9)];
         if ($urandom_range(0, 2) == 0) data_i = $urandom;
         else data_i = m_count + $urandom_range(0, 6);
         raddr_i = addrs[$urandom_range(0, 9)];
         int_i = 6'($urandom);
         excepttype_i = ($urandom_range(0, 9) < 6) ? 32'd0 : etypes[$urandom_range(0, 6)];
         current_inst_addr_i = $urandom;
         is_in_delayslot_i = $urandom_range(0, 1) == 1;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
